// File: rtl/interval_counter_bank.sv
// Bank of NUM_CH independent interval counters: start/stop measure a cycle count into a result register.
// Define INTERVAL_COUNTER_SATURATE_EN to saturate counters at all-ones instead of wrapping.
module interval_counter_bank #(
    parameter int NUM_CH = 4,
    parameter int WIDTH  = 32
) (
    input  logic                    clk_in,
    input  logic                    rst,
    input  logic [NUM_CH-1:0]       start,
    input  logic [NUM_CH-1:0]       stop,
    input  logic [NUM_CH-1:0]       result_ack,
    output logic [NUM_CH-1:0]       busy,
    output logic [NUM_CH*WIDTH-1:0] count,
    output logic [NUM_CH*WIDTH-1:0] result,
    output logic [NUM_CH-1:0]       result_valid,
    output logic [NUM_CH-1:0]       overflow,
    output logic [NUM_CH-1:0]       overrun
);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_COUNT = 1'b1
    } state_t;

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        state_t           state_q, state_d;
        logic [WIDTH-1:0] count_q, count_d;
        logic [WIDTH-1:0] result_q, result_d;
        logic [WIDTH-1:0] count_inc;
        logic             valid_q, valid_d;
        logic             ovf_q, ovf_d;
        logic             ovr_q, ovr_d;
        logic             at_max;
        logic             capture;

        always_comb begin
            at_max = &count_q;
`ifdef INTERVAL_COUNTER_SATURATE_EN
            count_inc = at_max ? count_q : count_q + WIDTH'(1);
`else
            count_inc = count_q + WIDTH'(1);
`endif
            state_d  = state_q;
            count_d  = count_q;
            result_d = result_q;
            valid_d  = valid_q;
            ovf_d    = ovf_q;
            ovr_d    = ovr_q;
            capture  = 1'b0;

            // Stop is ignored while idle, so start+stop together simply opens an interval.
            if (state_q == ST_IDLE) begin
                if (start[gi]) begin
                    state_d = ST_COUNT;
                    count_d = '0;
                    ovf_d   = 1'b0;
                end
            end else begin
                count_d = count_inc;
                if (at_max) begin
                    ovf_d = 1'b1;
                end
                if (stop[gi]) begin
                    capture = 1'b1;
                    state_d = ST_IDLE;
                end
            end

            // The captured value is the post-increment count of the stop cycle.
            if (capture) begin
                result_d = count_inc;
                valid_d  = 1'b1;
                if (valid_q) begin
                    ovr_d = ~result_ack[gi];
                end
            end else if (result_ack[gi] && valid_q) begin
                valid_d = 1'b0;
                ovr_d   = 1'b0;
            end
        end

        always_ff @(posedge clk_in) begin
            if (rst) begin
                state_q  <= ST_IDLE;
                count_q  <= '0;
                result_q <= '0;
                valid_q  <= 1'b0;
                ovf_q    <= 1'b0;
                ovr_q    <= 1'b0;
            end else begin
                state_q  <= state_d;
                count_q  <= count_d;
                result_q <= result_d;
                valid_q  <= valid_d;
                ovf_q    <= ovf_d;
                ovr_q    <= ovr_d;
            end
        end

        assign busy[gi]                     = (state_q == ST_COUNT);
        assign count[gi*WIDTH +: WIDTH]     = count_q;
        assign result[gi*WIDTH +: WIDTH]    = result_q;
        assign result_valid[gi]             = valid_q;
        assign overflow[gi]                 = ovf_q;
        assign overrun[gi]                  = ovr_q;
    end

endmodule

// File: tb/tb_interval_counter_bank.sv
// Directed bench for interval_counter_bank: a 4x32 instance driven from a vector table plus
// hand sequences, and a 1x8 instance for the wrap/saturate interval.
module tb_interval_counter_bank;

    logic         clk_in = 1'b0;
    logic         rst;
    logic [3:0]   start, stop, ack;
    logic [3:0]   busy, valid, ovf, ovr;
    logic [127:0] count, result;

    logic         rst8, start8, stop8, ack8;
    logic         busy8, valid8, ovf8, ovr8;
    logic [7:0]   count8, result8;

    int n_vec = 0;
    int n_bad = 0;

`ifdef INTERVAL_COUNTER_SATURATE_EN
    localparam logic [31:0] EXP_LONG = 32'd255;
`else
    localparam logic [31:0] EXP_LONG = 32'd4;
`endif

    always #5 clk_in = ~clk_in;

    interval_counter_bank #(.NUM_CH(4), .WIDTH(32)) dut (
        .clk_in(clk_in), .rst(rst), .start(start), .stop(stop), .result_ack(ack),
        .busy(busy), .count(count), .result(result), .result_valid(valid),
        .overflow(ovf), .overrun(ovr)
    );

    interval_counter_bank #(.NUM_CH(1), .WIDTH(8)) dut8 (
        .clk_in(clk_in), .rst(rst8), .start(start8), .stop(stop8), .result_ack(ack8),
        .busy(busy8), .count(count8), .result(result8), .result_valid(valid8),
        .overflow(ovf8), .overrun(ovr8)
    );

    typedef struct {
        logic        r;
        logic [3:0]  st, sp, ak;
        logic [3:0]  e_busy, e_valid, e_ovr;
        logic [31:0] e_cnt, e_res;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic [3:0] st, input logic [3:0] sp,
                       input logic [3:0] ak, input logic [3:0] eb, input logic [3:0] ev,
                       input logic [3:0] eo, input logic [31:0] ec, input logic [31:0] er);
        vec_t v;
        v.r = r; v.st = st; v.sp = sp; v.ak = ak;
        v.e_busy = eb; v.e_valid = ev; v.e_ovr = eo; v.e_cnt = ec; v.e_res = er;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    initial begin
        rst = 1'b1; start = '0; stop = '0; ack = '0;
        rst8 = 1'b1; start8 = 1'b0; stop8 = 1'b0; ack8 = 1'b0;

        //  rst start stop ack  busy valid ovr  cnt0 res0
        add(1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 0, 0);
        add(0, 4'h1, 4'h1, 4'h0, 4'h1, 4'h0, 4'h0, 0, 0);
        add(0, 4'h0, 4'h1, 4'h0, 4'h0, 4'h1, 4'h0, 1, 1);
        add(0, 4'h0, 4'h0, 4'h1, 4'h0, 4'h0, 4'h0, 1, 1);
        add(0, 4'h0, 4'h0, 4'h1, 4'h0, 4'h0, 4'h0, 1, 1);
        add(0, 4'h1, 4'h0, 4'h0, 4'h1, 4'h0, 4'h0, 0, 1);
        add(0, 4'h0, 4'h0, 4'h0, 4'h1, 4'h0, 4'h0, 1, 1);
        add(0, 4'h0, 4'h1, 4'h0, 4'h0, 4'h1, 4'h0, 2, 2);
        add(0, 4'h1, 4'h0, 4'h0, 4'h1, 4'h1, 4'h0, 0, 2);
        add(0, 4'h0, 4'h0, 4'h0, 4'h1, 4'h1, 4'h0, 1, 2);
        add(0, 4'h0, 4'h0, 4'h0, 4'h1, 4'h1, 4'h0, 2, 2);
        add(0, 4'h0, 4'h0, 4'h0, 4'h1, 4'h1, 4'h0, 3, 2);
        add(0, 4'h0, 4'h1, 4'h0, 4'h0, 4'h1, 4'h1, 4, 4);
        add(0, 4'h0, 4'h0, 4'h1, 4'h0, 4'h0, 4'h0, 4, 4);
        add(0, 4'h1, 4'h0, 4'h0, 4'h1, 4'h0, 4'h0, 0, 4);
        add(0, 4'h0, 4'h1, 4'h0, 4'h0, 4'h1, 4'h0, 1, 1);
        add(0, 4'h1, 4'h0, 4'h0, 4'h1, 4'h1, 4'h0, 0, 1);
        add(0, 4'h1, 4'h0, 4'h0, 4'h1, 4'h1, 4'h0, 1, 1);
        add(0, 4'h0, 4'h1, 4'h1, 4'h0, 4'h1, 4'h0, 2, 2);
        add(0, 4'h0, 4'h0, 4'h1, 4'h0, 4'h0, 4'h0, 2, 2);
        add(1, 4'h1, 4'h1, 4'h1, 4'h0, 4'h0, 4'h0, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            rst = vecs[i].r; start = vecs[i].st; stop = vecs[i].sp; ack = vecs[i].ak;
            step();
            chk($sformatf("v%0d busy", i),    {28'd0, busy},  {28'd0, vecs[i].e_busy});
            chk($sformatf("v%0d valid", i),   {28'd0, valid}, {28'd0, vecs[i].e_valid});
            chk($sformatf("v%0d overrun", i), {28'd0, ovr},   {28'd0, vecs[i].e_ovr});
            chk($sformatf("v%0d count0", i),  count[31:0],    vecs[i].e_cnt);
            chk($sformatf("v%0d result0", i), result[31:0],   vecs[i].e_res);
            $display("vec %0d: rst=%0b start=%h stop=%h ack=%h -> busy=%h valid=%h ovr=%h cnt0=%0d res0=%0d",
                     i, vecs[i].r, vecs[i].st, vecs[i].sp, vecs[i].ak, busy, valid, ovr,
                     count[31:0], result[31:0]);
        end

        // Basic interval of 5 cycles on ch0.
        rst = 1'b0; start = 4'h0; stop = 4'h0; ack = 4'h0;
        start = 4'h1;
        step();
        start = 4'h0;
        chk("k5 busy at start", {31'd0, busy[0]}, 32'd1);
        for (int i = 1; i <= 4; i++) begin
            step();
            chk($sformatf("k5 count %0d", i), count[31:0], i);
            chk($sformatf("k5 busy %0d", i), {31'd0, busy[0]}, 32'd1);
        end
        stop = 4'h1;
        step();
        stop = 4'h0;
        chk("k5 busy end", {31'd0, busy[0]}, 32'd0);
        chk("k5 valid", {31'd0, valid[0]}, 32'd1);
        chk("k5 result", result[31:0], 32'd5);
        step();
        chk("k5 count hold", count[31:0], 32'd5);
        $display("seq k5: result0=%0d", result[31:0]);

        // Overlapping intervals on ch1 (k=3) and ch2 (k=7).
        rst = 1'b1; step(); rst = 1'b0;
        for (int t = 0; t < 10; t++) begin
            start = (t == 0) ? 4'b0100 : (t == 1) ? 4'b0010 : 4'b0000;
            stop  = (t == 4) ? 4'b0010 : (t == 7) ? 4'b0100 : 4'b0000;
            step();
            if (t == 5) chk("overlap busy mid", {28'd0, busy}, 32'h4);
        end
        start = 4'h0; stop = 4'h0;
        chk("overlap res1", result[63:32], 32'd3);
        chk("overlap res2", result[95:64], 32'd7);
        chk("overlap valid", {28'd0, valid}, 32'h6);
        chk("overlap busy", {28'd0, busy}, 32'h0);
        chk("overlap ch0/ch3 count", count[31:0] | count[127:96], 32'd0);
        chk("overlap ch0/ch3 result", result[31:0] | result[127:96], 32'd0);
        $display("seq overlap: res1=%0d res2=%0d", result[63:32], result[95:64]);

        // Reset mid-count on ch2 with a coincident stop.
        rst = 1'b1; step(); rst = 1'b0;
        start = 4'b0100; step(); start = 4'h0;
        step(); step(); step();
        rst = 1'b1; stop = 4'b0100;
        step();
        rst = 1'b0; stop = 4'h0;
        chk("rst busy", {28'd0, busy}, 32'd0);
        chk("rst count2", count[95:64], 32'd0);
        chk("rst valid", {28'd0, valid}, 32'd0);
        chk("rst result2", result[95:64], 32'd0);
        start = 4'b0100; step(); start = 4'h0;
        chk("post-rst start", {28'd0, busy}, 32'h4);
        $display("seq reset: busy=%h valid=%h", busy, valid);

        // Long interval on the 8-bit instance: 260 increments crosses all-ones.
        rst8 = 1'b0;
        start8 = 1'b1; step(); start8 = 1'b0;
        for (int i = 1; i <= 255; i++) step();
        chk("w8 count 255", {24'd0, count8}, 32'd255);
        chk("w8 no ovf yet", {31'd0, ovf8}, 32'd0);
        for (int i = 0; i < 4; i++) step();
        stop8 = 1'b1; step(); stop8 = 1'b0;
        chk("w8 overflow", {31'd0, ovf8}, 32'd1);
        chk("w8 result", {24'd0, result8}, EXP_LONG);
        chk("w8 count", {24'd0, count8}, EXP_LONG);
        chk("w8 valid", {31'd0, valid8}, 32'd1);
        step();
        chk("w8 ovf sticky", {31'd0, ovf8}, 32'd1);
        start8 = 1'b1; step(); start8 = 1'b0;
        chk("w8 ovf cleared", {31'd0, ovf8}, 32'd0);
        $display("seq w8: result=%0d", result8);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
